// File: rtl/pci_arb_pkg.sv
// Shared types and defaults for the PCI bus arbiter.
// PCI_ARB_PARK_EN adds the PARK state (bus parking on the last owner).
package pci_arb_pkg;

    localparam int NREQ_DEF        = 4;
    localparam int GNT_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        BUSY,
        GAP
`ifdef PCI_ARB_PARK_EN
        ,
        PARK
`endif
    } arb_state_e;

endpackage

// File: rtl/pci_rr_pick.sv
// Round-robin winner search over active-low requests.
// The search starts one past the current owner and wraps modulo NREQ.
module pci_rr_pick
    import pci_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [2:0]      i_owner,
    output logic [2:0]      o_winner,
    output logic            o_valid
);

    int v_best;
    int v_dist;

    // Each requester's distance from owner+1; the nearest one wins.
    always_comb begin
        o_winner = i_owner;
        o_valid  = 1'b0;
        v_best   = NREQ;
        v_dist   = 0;
        for (int j = 0; j < NREQ; j++) begin
            v_dist = (j + 2 * NREQ - 1 - int'(i_owner)) % NREQ;
            if (!i_req[j] && v_dist < v_best) begin
                v_best   = v_dist;
                o_winner = 3'(j);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with grant timeout and one-clock turnaround gap.
// Optional bus parking when PCI_ARB_PARK_EN is defined.
module pci_arbiter
    import pci_arb_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [NREQ-1:0] REQ,
    input  logic            FRAME,
    input  logic            IRDY,
    output logic [NREQ-1:0] GNT,
    output logic [2:0]      OWNER,
    output logic            BUS_IDLE
);

    localparam int CW = $clog2(GNT_TIMEOUT + 1);

    arb_state_e      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [2:0]      r_owner;
    logic            r_bus_idle;
    logic [CW-1:0]   r_cnt;

    logic [2:0]      w_winner;
    logic            w_valid;
    logic            w_idle;
    logic            w_arb;
    logic [NREQ-1:0] w_own_bit;
    logic [NREQ-1:0] w_pick;
    logic            w_own_req;

    pci_rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .i_req   (REQ),
        .i_owner (r_owner),
        .o_winner(w_winner),
        .o_valid (w_valid)
    );

    assign w_idle    = FRAME & IRDY;
    assign w_arb     = w_valid & w_idle;
    assign w_own_bit = NREQ'(1) << r_owner;
    assign w_pick    = ~(NREQ'(1) << w_winner);
    assign w_own_req = |(~REQ & w_own_bit);

`ifdef PCI_ARB_PARK_EN
    logic w_other_req;
    assign w_other_req = |(~REQ & ~w_own_bit);
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_gnt      <= '1;
            r_owner    <= 3'(NREQ - 1);
            r_bus_idle <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_bus_idle <= w_idle;
            unique case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_gnt   <= w_pick;
                        r_owner <= w_winner;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
`ifdef PCI_ARB_PARK_EN
                    else if (!w_valid && w_idle) begin
                        r_gnt   <= ~w_own_bit;
                        r_state <= PARK;
                    end
`endif
                end
                GRANT: begin
                    if (!FRAME) begin
                        r_state <= BUSY;
                    end else if (!w_own_req) begin
                        r_gnt   <= '1;
                        r_state <= GAP;
                    end else if (w_idle) begin
                        // Timeout counts only clocks the bus sat idle.
                        if (r_cnt == CW'(GNT_TIMEOUT - 1)) begin
                            r_gnt   <= '1;
                            r_state <= GAP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (r_bus_idle) begin
                        r_gnt   <= '1;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (w_arb) begin
                        r_gnt   <= w_pick;
                        r_owner <= w_winner;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
`ifdef PCI_ARB_PARK_EN
                PARK: begin
                    if (!FRAME) begin
                        r_state <= BUSY;
                    end else if (w_other_req) begin
                        r_gnt   <= '1;
                        r_state <= GAP;
                    end
                end
`endif
                default: begin
                    r_gnt   <= '1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign GNT      = r_gnt;
    assign OWNER    = r_owner;
    assign BUS_IDLE = r_bus_idle;

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter: random requests and bus traffic,
// expected grant timing from a round-robin reference model.
module tb_pci_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    typedef struct {
        int cyc;
        int w;
        int len;
    } exp_t;

    logic       CLK   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] REQ   = 4'hF;
    logic       FRAME = 1'b1;
    logic       IRDY  = 1'b1;
    logic [3:0] GNT;
    logic [2:0] OWNER;
    logic       BUS_IDLE;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_owner = NREQ - 1;
    logic exp_bi = 1'b1;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    pci_arbiter #(
        .NREQ(NREQ),
        .GNT_TIMEOUT(TMO)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .REQ(REQ),
        .FRAME(FRAME),
        .IRDY(IRDY),
        .GNT(GNT),
        .OWNER(OWNER),
        .BUS_IDLE(BUS_IDLE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK or negedge reset)
        if (!reset) exp_bi <= 1'b1;
        else exp_bi <= FRAME & IRDY;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] pat, input int own);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (own + k) % NREQ;
            if (pat[idx[1:0]] == 1'b0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] mask(input int w);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << w);
    endfunction

    // kind 0: master runs a transfer of prm busy clocks
    // kind 1: master drops its request prm clocks after the grant
    // kind 2: master never starts, grant times out
    task automatic issue(input logic [3:0] pat, input int kind, input int prm);
        int w;
        int len;
        logic [3:0] bitw;
        w = rr(pat, model_owner);
        model_owner = w;
        bitw = ~mask(w);
        if (kind == 0) len = prm + 2;
        else if (kind == 1) len = prm + 1;
        else len = TMO;
        REQ = pat;
        exp_q.push_back('{cyc + 1, w, len});
        for (int s = 0; s < len; s++) begin
            @(negedge CLK);
            if (kind == 0) begin
                REQ = 4'($urandom);
                if (s == 0) begin
                    FRAME = 1'b0;
                    IRDY  = 1'b0;
                end
                if (s == prm) begin
                    FRAME = 1'b1;
                    IRDY  = 1'b1;
                end
            end else if (kind == 1 && s == prm) begin
                REQ = 4'($urandom) | bitw;
            end else begin
                REQ = 4'($urandom) & ~bitw;
            end
        end
        @(negedge CLK);
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0] cur_mask;
        int cur_len;
        int glen;
        bit active;
        active = 1'b0;
        cur_mask = 4'hF;
        cur_len = 0;
        glen = 0;
        forever begin
            @(negedge CLK);
            if (reset) chk("bus_idle", int'(BUS_IDLE), int'(exp_bi));
            if (!mon_en) begin
                active = 1'b0;
            end else if (!active) begin
                if (GNT != 4'hF) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_grant", int'(GNT), 15);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_cycle", cyc, e.cyc);
                        chk("grant_vec", int'(GNT), int'(mask(e.w)));
                        chk("owner", int'(OWNER), e.w);
                        cur_mask = mask(e.w);
                        cur_len = e.len;
                        glen = 1;
                        active = 1'b1;
                    end
                end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                    chk("grant_missing", int'(GNT), int'(mask(exp_q[0].w)));
                    exp_q.delete(0);
                end
            end else begin
                if (GNT == 4'hF) begin
                    chk("grant_len", glen, cur_len);
                    active = 1'b0;
                end else begin
                    chk("grant_hold", int'(GNT), int'(cur_mask));
                    glen++;
                end
            end
        end
    end

    task automatic main_seq();
        logic [3:0] pat;
        int kind;
        int prm;
        int r;
        int w;
        pat = 4'b1110;
        mon_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 5);
            if (r < 3) begin
                kind = 0;
                prm = $urandom_range(1, 6);
            end else if (r < 5) begin
                kind = 1;
                prm = $urandom_range(0, 3);
            end else begin
                kind = 2;
                prm = 0;
            end
            if (t == 2) kind = 2;
            if (t == 4) begin
                kind = 0;
                prm = 5;
            end
            issue(pat, kind, prm);
            if (t < 4) pat = 4'b0000;
            else if (t == 4) pat = 4'b1101;
            else if ($urandom_range(0, 4) == 0) pat = 4'hF;
            else pat = 4'($urandom_range(0, 14));
            if (pat == 4'hF) begin
                REQ = 4'hF;
                r = $urandom_range(1, 3);
                for (int i = 0; i < r; i++) begin
                    @(negedge CLK);
                    chk("idle_no_grant", int'(GNT), 15);
                end
                pat = 4'($urandom_range(0, 14));
            end
        end
        REQ = 4'hF;
        repeat (3) @(negedge CLK);

        // reset pulse in the middle of a transfer
        mon_en = 1'b0;
        pat = 4'b1011;
        w = rr(pat, model_owner);
        model_owner = w;
        REQ = pat;
        @(negedge CLK);
        chk("direct_grant", int'(GNT), int'(mask(w)));
        FRAME = 1'b0;
        IRDY = 1'b0;
        repeat (2) @(negedge CLK);
        chk("busy_hold", int'(GNT), int'(mask(w)));
        #2 reset = 1'b0;
        #1;
        chk("async_reset_gnt", int'(GNT), 15);
        chk("async_reset_owner", int'(OWNER), NREQ - 1);
        @(negedge CLK);
        reset = 1'b1;
        model_owner = NREQ - 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("no_grant_while_busy", int'(GNT), 15);
        end
        FRAME = 1'b1;
        IRDY = 1'b1;
        mon_en = 1'b1;
        issue(4'b1011, 1, 0);
        REQ = 4'hF;
        repeat (2) @(negedge CLK);
    endtask

    task automatic park_seq();
        mon_en = 1'b0;
        REQ = 4'b1101;
        @(negedge CLK);
        chk("park_first_grant", int'(GNT), 4'b1101);
        REQ = 4'hF;
        repeat (3) @(negedge CLK);
        chk("park_gnt", int'(GNT), 4'b1101);
        REQ = 4'b0111;
        @(negedge CLK);
        chk("park_release_gap", int'(GNT), 15);
        @(negedge CLK);
        chk("park_next_grant", int'(GNT), 4'b0111);
        REQ = 4'hF;
        repeat (2) @(negedge CLK);
    endtask

    initial begin : stim
        #12;
        chk("reset_gnt", int'(GNT), 15);
        chk("reset_owner", int'(OWNER), NREQ - 1);
        chk("reset_bus_idle", int'(BUS_IDLE), 1);
        @(negedge CLK);
        reset = 1'b1;
        model_owner = NREQ - 1;
`ifdef PCI_ARB_PARK_EN
        park_seq();
`else
        main_seq();
`endif
        repeat (3) @(negedge CLK);
        chk("queue_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
